// File: rtl/mem_stage_unit.sv
// MEM pipeline stage with a private word-organised data RAM, byte/half/word access and configurable latency.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses are suppressed and flagged on misalign.
module mem_stage_unit #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              load_signed,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              rdata_valid,
    output logic [31:0]       rdata,
    output logic              misalign
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

    stateT             state;
    logic [2:0]        cnt;
    logic [31:0]       mem [DEPTH];

    logic [IDX_W+1:0]  capAddr;
    logic [1:0]        capSize;
    logic              capSigned;
    logic [31:0]       capWdata;
    logic              capRead;
    logic              capWrite;

    logic              accept;
    logic              finish;
    logic              useCap;
    logic [IDX_W+1:0]  curAddr;
    logic [1:0]        curSize;
    logic              curSigned;
    logic [31:0]       curWdata;
    logic              curRead;
    logic              curWrite;
    logic [IDX_W-1:0]  curIdx;
    logic [31:0]       curWord;
    logic [31:0]       newWord;
    logic [31:0]       loadVal;
    logic [7:0]        byteField;
    logic [15:0]       halfField;
    logic              misTrap;

    // Upper address bits only alias; they never select anything.
    if (ADDR_W > IDX_W + 2) begin : gAddrHi
        logic unusedAddrHi;
        assign unusedAddrHi = ^addr[ADDR_W-1:IDX_W+2];
    end

    // A new access may start in IDLE or in the RESP cycle of the previous one.
    assign accept = (state != BUSY) && req_valid && (mem_read || mem_write);
    assign finish = (accept && LATENCY == 1) || (state == BUSY && cnt == 3'd1);
    assign stall  = (accept && LATENCY > 1) || (state == BUSY);

    // Finishing work uses live inputs for single-cycle access, captured ones otherwise.
    assign useCap    = (state == BUSY);
    assign curAddr   = useCap ? capAddr   : addr[IDX_W+1:0];
    assign curSize   = useCap ? capSize   : size;
    assign curSigned = useCap ? capSigned : load_signed;
    assign curWdata  = useCap ? capWdata  : wdata;
    assign curRead   = useCap ? capRead   : mem_read;
    assign curWrite  = useCap ? capWrite  : mem_write;
    assign curIdx    = curAddr[IDX_W+1:2];
    assign curWord   = mem[curIdx];

`ifdef MISALIGN_TRAP_EN
    assign misTrap = (curSize == 2'b01) ? curAddr[0] :
                     (curSize[1])       ? (curAddr[1:0] != 2'b00) : 1'b0;
`else
    assign misTrap = 1'b0;
`endif

    always_comb begin
        newWord = curWord;
        case (curSize)
            2'b00: newWord[8*curAddr[1:0] +: 8] = curWdata[7:0];
            2'b01: begin
                if (curAddr[1]) newWord[31:16] = curWdata[15:0];
                else            newWord[15:0]  = curWdata[15:0];
            end
            default: newWord = curWdata;
        endcase
    end

    always_comb begin
        byteField = curWord[8*curAddr[1:0] +: 8];
        halfField = curAddr[1] ? curWord[31:16] : curWord[15:0];
        case (curSize)
            2'b00:   loadVal = curSigned ? {{24{byteField[7]}}, byteField} : {24'b0, byteField};
            2'b01:   loadVal = curSigned ? {{16{halfField[15]}}, halfField} : {16'b0, halfField};
            default: loadVal = curWord;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            rdata_valid <= 1'b0;
            rdata       <= 32'd0;
            misalign    <= 1'b0;
            capAddr     <= '0;
            capSize     <= 2'b00;
            capSigned   <= 1'b0;
            capWdata    <= 32'd0;
            capRead     <= 1'b0;
            capWrite    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else begin
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            case (state)
                BUSY: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) state <= RESP;
                end
                default: begin
                    if (accept) begin
                        capAddr   <= addr[IDX_W+1:0];
                        capSize   <= size;
                        capSigned <= load_signed;
                        capWdata  <= wdata;
                        capRead   <= mem_read;
                        capWrite  <= mem_write;
                        if (LATENCY > 1) begin
                            state <= BUSY;
                            cnt   <= 3'(LATENCY - 1);
                        end else begin
                            state <= RESP;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
            // Commit point: stores write, loads (without a store) respond next cycle.
            if (finish) begin
                if (misTrap) begin
                    misalign <= 1'b1;
                end else if (curWrite) begin
                    mem[curIdx] <= newWord;
                end else if (curRead) begin
                    rdata       <= loadVal;
                    rdata_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: one LATENCY=1 and one LATENCY=3 instance, scoreboarded load responses.
module tb_mem_stage_unit;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst1, rst3;

  logic        req_valid1, mem_read1, mem_write1, load_signed1;
  logic [1:0]  size1;
  logic [31:0] addr1, wdata1;
  logic        stall1, rdata_valid1, misalign1;
  logic [31:0] rdata1;

  logic        req_valid3, mem_read3, mem_write3, load_signed3;
  logic [1:0]  size3;
  logic [31:0] addr3, wdata3;
  logic        stall3, rdata_valid3, misalign3;
  logic [31:0] rdata3;

  mem_stage_unit #(.ADDR_W(32), .DEPTH(256), .LATENCY(1)) u1 (
    .clk(clk), .reset(rst1), .req_valid(req_valid1), .mem_read(mem_read1),
    .mem_write(mem_write1), .size(size1), .load_signed(load_signed1), .addr(addr1),
    .wdata(wdata1), .stall(stall1), .rdata_valid(rdata_valid1), .rdata(rdata1),
    .misalign(misalign1)
  );

  mem_stage_unit #(.ADDR_W(32), .DEPTH(256), .LATENCY(3)) u3 (
    .clk(clk), .reset(rst3), .req_valid(req_valid3), .mem_read(mem_read3),
    .mem_write(mem_write3), .size(size3), .load_signed(load_signed3), .addr(addr3),
    .wdata(wdata3), .stall(stall3), .rdata_valid(rdata_valid3), .rdata(rdata3),
    .misalign(misalign3)
  );

  // scoreboard state
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q3[$];
  logic [31:0] model1[256];
  logic [31:0] model3[256];
  int tests_run = 0;
  int tests_failed = 0;
  int stall1_hi = 0;
  int mis_seen1 = 0, mis_seen3 = 0;
  int exp_mis1 = 0, exp_mis3 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [1:0] sz,
                                             input logic [1:0] ofs, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (sz)
      2'd0: r[8*ofs +: 8] = wd[7:0];
      2'd1: if (ofs[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract_word(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] ofs, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8*ofs));
    h = ofs[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0: return sg ? {{24{b[7]}}, b} : {24'b0, b};
      2'd1: return sg ? {{16{h[15]}}, h} : {16'b0, h};
      default: return w;
    endcase
  endfunction

  // driver: one access, returns in the cycle where the next access may be presented
  task automatic do_op(input int inst, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                       input logic use_lit, input logic [31:0] lit);
    logic [7:0]  idx;
    logic        mis;
    logic [31:0] ev;
    idx = ad[9:2];
    mis = TRAP && ((sz == 2'd1 && ad[0]) || (sz[1] && ad[1:0] != 2'b00));
    if (mis) begin
      if (inst == 1) exp_mis1++; else exp_mis3++;
    end else if (wr) begin
      if (inst == 1) model1[idx] = merge_word(model1[idx], sz, ad[1:0], wd);
      else           model3[idx] = merge_word(model3[idx], sz, ad[1:0], wd);
    end else if (rd) begin
      ev = extract_word((inst == 1) ? model1[idx] : model3[idx], sz, ad[1:0], sg);
      if (use_lit) ev = lit;
      if (inst == 1) exp_q1.push_back(ev); else exp_q3.push_back(ev);
    end
    if (inst == 1) begin
      req_valid1 = 1'b1; mem_read1 = rd; mem_write1 = wr; size1 = sz;
      load_signed1 = sg; addr1 = ad; wdata1 = wd;
      @(posedge clk); #1;
      req_valid1 = 1'b0;
    end else begin
      req_valid3 = 1'b1; mem_read3 = rd; mem_write3 = wr; size3 = sz;
      load_signed3 = sg; addr3 = ad; wdata3 = wd;
      @(posedge clk); #1;
      req_valid3 = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
    end
  endtask

  task automatic rand_op(input int inst);
    logic [1:0]  sz;
    logic [1:0]  ofs;
    int          op;
    sz  = 2'($urandom_range(0, 2));
    ofs = 2'($urandom_range(0, 3));
    if (sz == 2'd1) ofs[0] = 1'b0;
    if (sz == 2'd2) ofs = 2'b00;
    op = $urandom_range(0, 2);
    do_op(inst, op != 1, op != 0, sz, 1'($urandom_range(0, 1)),
          32'h100 + 32'($urandom_range(0, 7)) * 4 + {30'b0, ofs}, $urandom, 1'b0, 32'd0);
  endtask

  // response monitors
  always @(negedge clk) begin
    if (!rst1) begin
      if (stall1) stall1_hi++;
      if (misalign1) mis_seen1++;
      if (rdata_valid1) begin
        if (exp_q1.size() == 0) check_eq("rv1_unexpected", {31'b0, rdata_valid1}, 32'd0);
        else check_eq("rdata1", rdata1, exp_q1.pop_front());
      end
    end
    if (!rst3) begin
      if (misalign3) mis_seen3++;
      if (rdata_valid3) begin
        if (exp_q3.size() == 0) check_eq("rv3_unexpected", {31'b0, rdata_valid3}, 32'd0);
        else check_eq("rdata3", rdata3, exp_q3.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin model1[i] = 32'd0; model3[i] = 32'd0; end
    rst1 = 1'b1; rst3 = 1'b1;
    req_valid1 = 0; mem_read1 = 0; mem_write1 = 0; size1 = 0; load_signed1 = 0; addr1 = 0; wdata1 = 0;
    req_valid3 = 0; mem_read3 = 0; mem_write3 = 0; size3 = 0; load_signed3 = 0; addr3 = 0; wdata3 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall1", {31'b0, stall1}, 32'd0);
    check_eq("rst_rv1", {31'b0, rdata_valid1}, 32'd0);
    check_eq("rst_rdata1", rdata1, 32'd0);
    check_eq("rst_mis1", {31'b0, misalign1}, 32'd0);
    check_eq("rst_stall3", {31'b0, stall3}, 32'd0);
    check_eq("rst_rdata3", rdata3, 32'd0);
    @(posedge clk); #1;
    rst1 = 1'b0; rst3 = 1'b0;

    // LATENCY=1 directed
    do_op(1, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 0);
    do_op(1, 1, 0, 2'd2, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF);
    do_op(1, 0, 1, 2'd2, 0, 32'h20, 32'h11223344, 0, 0);
    do_op(1, 0, 1, 2'd0, 0, 32'h21, 32'h00000080, 0, 0);
    do_op(1, 1, 0, 2'd0, 1, 32'h21, 32'h0, 1, 32'hFFFFFF80);
    do_op(1, 1, 0, 2'd1, 0, 32'h20, 32'h0, 1, 32'h00008044);
    do_op(1, 1, 0, 2'd2, 0, 32'h20, 32'h0, 1, 32'h11228044);
    do_op(1, 0, 1, 2'd2, 0, 32'h400, 32'hA5A55A5A, 0, 0);
    do_op(1, 1, 0, 2'd2, 0, 32'h000, 32'h0, 1, 32'hA5A55A5A);
    do_op(1, 1, 1, 2'd2, 0, 32'h30, 32'h12345678, 0, 0);
    do_op(1, 1, 0, 2'd2, 0, 32'h30, 32'h0, 1, 32'h12345678);
    do_op(1, 1, 0, 2'd2, 0, 32'h13, 32'h0, 1, 32'hDEADBEEF);
    for (int i = 0; i < 40; i++) rand_op(1);

    // LATENCY=3: stall window and request capture
    do_op(3, 0, 1, 2'd2, 0, 32'h08, 32'hCAFEF00D, 0, 0);
    exp_q3.push_back(32'hCAFEF00D);
    req_valid3 = 1; mem_read3 = 1; mem_write3 = 0; size3 = 2'd2; load_signed3 = 0; addr3 = 32'h08;
    @(negedge clk);
    check_eq("l3_stall_c0", {31'b0, stall3}, 32'd1);
    @(posedge clk); #1;
    req_valid3 = 0; addr3 = 32'h41; size3 = 2'd0; load_signed3 = 1;
    @(negedge clk);
    check_eq("l3_stall_c1", {31'b0, stall3}, 32'd1);
    check_eq("l3_rv_c1", {31'b0, rdata_valid3}, 32'd0);
    @(posedge clk); #1;
    addr3 = 32'h7E; size3 = 2'd1;
    @(negedge clk);
    check_eq("l3_stall_c2", {31'b0, stall3}, 32'd1);
    check_eq("l3_rv_c2", {31'b0, rdata_valid3}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("l3_stall_c3", {31'b0, stall3}, 32'd0);
    check_eq("l3_rv_c3", {31'b0, rdata_valid3}, 32'd1);
    @(posedge clk); #1;

    // LATENCY=3: reset in cycle 1 of a store aborts it
    req_valid3 = 1; mem_read3 = 0; mem_write3 = 1; size3 = 2'd2; addr3 = 32'h10; wdata3 = 32'h55;
    @(posedge clk); #1;
    req_valid3 = 0; rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    for (int i = 0; i < 256; i++) model3[i] = 32'd0;
    repeat (4) begin @(posedge clk); #1; end
    do_op(3, 1, 0, 2'd2, 0, 32'h10, 32'h0, 1, 32'h00000000);
    for (int i = 0; i < 12; i++) rand_op(3);

    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("q1_drained", exp_q1.size(), 32'd0);
    check_eq("q3_drained", exp_q3.size(), 32'd0);
    check_eq("stall1_never", stall1_hi, 32'd0);
    check_eq("misalign1_count", mis_seen1, exp_mis1);
    check_eq("misalign3_count", mis_seen3, exp_mis3);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
